// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
//   state_e    : grant FSM encoding (IDLE / GNT_A / GNT_B)
//   SRC_A/B    : source tags carried alongside the output beat
//   tie_winner : which side wins a simultaneous request from IDLE
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // The side that did not hold the most recent grant wins a tie.
    function automatic logic tie_winner(input logic last_gnt);
        return (last_gnt == SRC_B) ? SRC_A : SRC_B;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_out.sv
// Registered 2:1 data mux with load enable (module mux2_out_reg).
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   sel_i          : 0 selects data_a_i, 1 selects data_b_i
//   load_i         : capture the selected beat this cycle
//   drain_i        : downstream accepted the currently held beat
//   data_a_i/b_i   : source data
//   out_data_o, out_src_o, out_valid_o : output register
module mux2_out_reg
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          sel_i,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [DW-1:0] data_a_i,
    input  logic [DW-1:0] data_b_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_src_o,
    output logic          out_valid_o
);

    logic [DW-1:0] data_q, data_d;
    logic          src_q, src_d;
    logic          valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (load_i) begin
            // A load wins over a drain: the new beat replaces the old one.
            data_d  = sel_i ? data_b_i : data_a_i;
            src_d   = sel_i ? SRC_B : SRC_A;
            valid_d = 1'b1;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            src_q   <= SRC_A;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_src_o   = src_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 mux between requesters A and B.
// Each grant is limited to MAX_BURST beats while the other side is waiting.
//
// state | meaning
// IDLE  | no grant held, no transfers
// GNT_A | A owns the mux; beats from A transfer when the output can load
// GNT_B | B owns the mux; mirror of GNT_A
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_x/data_x/ack_x  : requester A/B handshake (ack is a combinational pulse)
//   gnt_a, gnt_b        : registered grant
//   out_valid/data/src  : output register, drained by out_ready
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic [DW-1:0] data_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic [DW-1:0] data_b,
    output logic          ack_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    input  logic          out_ready
);

    state_e        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          last_q, last_d;
    logic          load_en;
    logic          at_limit;

    assign load_en  = !out_valid || out_ready;
    assign at_limit = (burst_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        ack_a   = 1'b0;
        ack_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a && req_b)
                    state_d = (tie_winner(last_q) == SRC_A) ? GNT_A : GNT_B;
                else if (req_a)
                    state_d = GNT_A;
                else if (req_b)
                    state_d = GNT_B;
            end
            GNT_A: begin
                ack_a = req_a && load_en;
                if (!req_a) begin
                    state_d = req_b ? GNT_B : IDLE;
                end else if (ack_a) begin
                    // At the limit the counter saturates; with B waiting the
                    // limiting beat hands over, otherwise A keeps the grant.
                    if (at_limit) begin
                        if (req_b)
                            state_d = GNT_B;
                    end else begin
                        burst_d = burst_q + CW'(1);
                    end
                end
            end
            GNT_B: begin
                ack_b = req_b && load_en;
                if (!req_b) begin
                    state_d = req_a ? GNT_A : IDLE;
                end else if (ack_b) begin
                    if (at_limit) begin
                        if (req_a)
                            state_d = GNT_A;
                    end else begin
                        burst_d = burst_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            burst_d = '0;
            if (state_d == GNT_A)
                last_d = SRC_A;
            else if (state_d == GNT_B)
                last_d = SRC_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= SRC_B;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    assign gnt_a = (state_q == GNT_A);
    assign gnt_b = (state_q == GNT_B);

    mux2_out_reg #(.DW(DW)) u_out_reg (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .sel_i       (state_q == GNT_B),
        .load_i      (ack_a || ack_b),
        .drain_i     (out_ready),
        .data_a_i    (data_a),
        .data_b_i    (data_b),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_valid_o (out_valid)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, out_ready;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, gnt_a, gnt_b, out_valid, out_src;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    mux2_rr_arbiter #(.DW(8), .MAX_BURST(MAXB), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B; last 1=A 2=B.
    int         m_owner = 0;
    int         m_last  = 2;
    int         m_run   = 0;
    logic       m_ov    = 1'b0;
    logic [7:0] m_od    = 8'h00;
    logic       m_os    = 1'b0;

    always @(negedge clk) begin
        logic e_ack_a, e_ack_b, mine, other;
        int   nxt;
        if (!rst_n) begin
            m_owner = 0; m_last = 2; m_run = 0;
            m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0;
            chk1("m_rst_gnt_a", gnt_a, 1'b0);
            chk1("m_rst_gnt_b", gnt_b, 1'b0);
            chk1("m_rst_ack_a", ack_a, 1'b0);
            chk1("m_rst_ack_b", ack_b, 1'b0);
            chk1("m_rst_valid", out_valid, 1'b0);
            chk8("m_rst_data", out_data, 8'h00);
        end else begin
            e_ack_a = (m_owner == 1) && req_a && (!m_ov || out_ready);
            e_ack_b = (m_owner == 2) && req_b && (!m_ov || out_ready);
            chk1("m_gnt_a", gnt_a, m_owner == 1);
            chk1("m_gnt_b", gnt_b, m_owner == 2);
            chk1("m_ack_a", ack_a, e_ack_a);
            chk1("m_ack_b", ack_b, e_ack_b);
            chk1("m_valid", out_valid, m_ov);
            chk8("m_data", out_data, m_od);
            chk1("m_src", out_src, m_os);

            if (e_ack_a) begin
                m_ov = 1'b1; m_od = data_a; m_os = 1'b0;
            end else if (e_ack_b) begin
                m_ov = 1'b1; m_od = data_b; m_os = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end

            nxt = m_owner;
            if (m_owner == 0) begin
                if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else begin
                mine  = (m_owner == 1) ? req_a : req_b;
                other = (m_owner == 1) ? req_b : req_a;
                if (!mine) begin
                    nxt = other ? 3 - m_owner : 0;
                end else if (e_ack_a || e_ack_b) begin
                    if (m_run + 1 >= MAXB && other) nxt = 3 - m_owner;
                    else m_run = (m_run + 1 < MAXB) ? m_run + 1 : MAXB - 1;
                end
            end
            if (nxt != m_owner) begin
                m_run = 0;
                if (nxt != 0) m_last = nxt;
            end
            m_owner = nxt;
        end
    end

    logic seen_a = 1'b0, seen_b = 1'b0;
    always @(negedge clk) begin
        seen_a = ack_a;
        seen_b = ack_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00; out_ready = 1'b1;

        at_neg();
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);

        // Single requester stream
        tick(); rst_n = 1'b1; req_a = 1'b1; data_a = 8'h11;
        at_neg(); chk1("ss_idle_gnt", gnt_a, 1'b0);
        tick();
        at_neg(); chk1("ss_gnt_a", gnt_a, 1'b1); chk1("ss_ack1", ack_a, 1'b1);
        tick(); data_a = 8'h22;
        at_neg(); chk1("ss_ack2", ack_a, 1'b1); chk8("ss_d11", out_data, 8'h11);
        chk1("ss_v1", out_valid, 1'b1); chk1("ss_src", out_src, 1'b0);
        tick(); data_a = 8'h33;
        at_neg(); chk1("ss_ack3", ack_a, 1'b1); chk8("ss_d22", out_data, 8'h22);
        tick(); req_a = 1'b0;
        at_neg(); chk8("ss_d33", out_data, 8'h33); chk1("ss_noack", ack_a, 1'b0);
        chk1("ss_gnt_hold", gnt_a, 1'b1);
        tick();
        // Requester drop -> IDLE
        at_neg(); chk1("drop_gnt_a", gnt_a, 1'b0); chk1("drop_gnt_b", gnt_b, 1'b0);
        chk1("drop_ack", ack_a, 1'b0); chk1("drop_valid", out_valid, 1'b0);

        // Tie after last grant A -> B first, then burst fairness
        tick(); req_a = 1'b1; req_b = 1'b1; data_a = 8'hAA; data_b = 8'hBB;
        at_neg(); chk1("tie_idle", gnt_b, 1'b0);
        tick();
        at_neg(); chk1("tie_gnt_b", gnt_b, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin tick(); at_neg(); end
            chk1("fair_ack_b", ack_b, ((k / MAXB) % 2) == 0);
            chk1("fair_ack_a", ack_a, ((k / MAXB) % 2) == 1);
            chk1("fair_excl", ack_a && ack_b, 1'b0);
        end
        tick(); req_a = 1'b0; req_b = 1'b0;
        tick(); tick();

        // Reset mid-operation
        req_a = 1'b1; data_a = 8'h77;
        tick(); tick();
        #1; rst_n = 1'b0;
        #1;
        chk1("mid_rst_gnt", gnt_a, 1'b0); chk1("mid_rst_ack", ack_a, 1'b0);
        chk1("mid_rst_valid", out_valid, 1'b0); chk8("mid_rst_data", out_data, 8'h00);
        req_a = 1'b0; req_b = 1'b1; data_b = 8'h4B;
        at_neg();
        tick(); rst_n = 1'b1;
        at_neg(); chk1("post_rst_idle", gnt_b, 1'b0);
        tick();
        at_neg(); chk1("post_rst_gnt_b", gnt_b, 1'b1); chk1("post_rst_ack_b", ack_b, 1'b1);
        tick(); req_b = 1'b0;
        tick(); tick();

        // Tie right after reset -> A first
        rst_n = 1'b0;
        at_neg();
        tick(); rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 8'h3C; data_b = 8'hC3;
        at_neg(); chk1("rtie_idle", gnt_a, 1'b0);
        tick();
        at_neg(); chk1("rtie_gnt_a", gnt_a, 1'b1); chk1("rtie_ack_a", ack_a, 1'b1);
        chk1("rtie_ack_b", ack_b, 1'b0);
        tick(); req_a = 1'b0; req_b = 1'b0;
        tick(); tick(); tick();

        // Backpressure
        req_a = 1'b1; data_a = 8'hA5; out_ready = 1'b1;
        tick();
        at_neg(); chk1("bp_ack0", ack_a, 1'b1);
        tick(); out_ready = 1'b0; data_a = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            at_neg();
            chk8("bp_hold", out_data, 8'hA5); chk1("bp_noack", ack_a, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
        end
        tick(); out_ready = 1'b1;
        at_neg(); chk1("bp_ack", ack_a, 1'b1); chk1("bp_valid_kept", out_valid, 1'b1);
        tick();
        at_neg(); chk8("bp_new", out_data, 8'h5A); chk1("bp_valid2", out_valid, 1'b1);
        tick(); req_a = 1'b0;
        tick(); tick();

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
            end
            if (!req_a || seen_a) begin
                req_a  = ($urandom_range(0, 3) != 0);
                data_a = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req_a = 1'b0;
            end
            if (!req_b || seen_b) begin
                req_b  = ($urandom_range(0, 3) != 0);
                data_b = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req_b = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
